// File: rtl/prio_enc64to6.sv
// Two-stage pipelined 64-to-6 priority encoder with valid/ready handshake.
// Stage 1 encodes eight 8-bit groups; stage 2 picks the winning group.
module prio_enc64to6 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] w,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [5:0]  y,
  output logic        z,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned NGRP = 8;
  localparam int unsigned GW   = 8;
  localparam int unsigned LW   = 3;
  localparam int unsigned IW   = 6;

  // Index of the winning bit in an 8-bit vector; 0 when nothing is set.
  function automatic logic [LW-1:0] pick8(input logic [GW-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < int'(GW); i++) begin
        if (v[i]) idx = LW'(i);
      end
    end else begin
      for (int i = int'(GW) - 1; i >= 0; i--) begin
        if (v[i]) idx = LW'(i);
      end
    end
    return idx;
  endfunction

  logic                     s1_valid;
  logic [NGRP-1:0]          s1_any;
  logic [NGRP-1:0][LW-1:0]  s1_loc;
  logic [NGRP-1:0]          s1_any_d;
  logic [NGRP-1:0][LW-1:0]  s1_loc_d;
  logic [LW-1:0]            g_win;
  logic [IW-1:0]            y_d;
  logic                     z_d;
  logic                     s1_ready;
  logic                     s2_ready;

  // Backpressure chain: each stage can accept when empty or draining this cycle.
  assign s2_ready = ~out_valid | out_ready;
  assign s1_ready = ~s1_valid | s2_ready;
  assign in_ready = s1_ready;

  // Per-group any-set flags and in-group winner; en=0 masks every group.
  always_comb begin
    s1_any_d = '0;
    s1_loc_d = '0;
    for (int g = 0; g < int'(NGRP); g++) begin
      s1_any_d[g] = en & (|w[g*GW +: GW]);
      s1_loc_d[g] = pick8(w[g*GW +: GW]);
    end
  end

  // Winning group selects its in-group location; empty word encodes as 0.
  always_comb begin
    g_win = pick8(s1_any);
    z_d   = |s1_any;
    y_d   = z_d ? {g_win, s1_loc[g_win]} : '0;
  end

  // Stage 1 register: loads on accept, empties when its beat moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_any   <= '0;
      s1_loc   <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_any <= s1_any_d;
        s1_loc <= s1_loc_d;
      end
    end
  end

  // Output register: holds y/z stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      z         <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y <= y_d;
        z <= z_d;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc64to6.sv
// Randomized and directed bench for prio_enc64to6; both priority polarities
// run side by side on the same stream and are checked against a reference model.
module tb_prio_enc64to6;

  logic        clk;
  logic        rst;
  logic        en;
  logic [63:0] w;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready_h, in_ready_l;
  logic [5:0]  y_h, y_l;
  logic        z_h, z_l;
  logic        out_valid_h, out_valid_l;

  int vectors;
  int miscompares;
  bit rnd_ready;

  typedef struct packed {
    logic [63:0] w;
    logic        en;
  } beat_t;

  beat_t exp_q[$];

  prio_enc64to6 #(.HIGH_FIRST(1'b1)) dut_h (
    .clk(clk), .rst(rst), .en(en), .w(w), .in_valid(in_valid),
    .in_ready(in_ready_h), .y(y_h), .z(z_h), .out_valid(out_valid_h),
    .out_ready(out_ready)
  );

  prio_enc64to6 #(.HIGH_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .en(en), .w(w), .in_valid(in_valid),
    .in_ready(in_ready_l), .y(y_l), .z(z_l), .out_valid(out_valid_l),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value to its expectation.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: scan the word from the priority end, first set bit wins.
  function automatic logic [5:0] ref_y(input logic [63:0] v, input logic e, input bit hf);
    if (!e || v == 64'd0) return 6'd0;
    if (hf) begin
      for (int k = 63; k >= 0; k--) begin
        if (v[k]) return 6'(k);
      end
    end else begin
      for (int k = 0; k < 64; k++) begin
        if (v[k]) return 6'(k);
      end
    end
    return 6'd0;
  endfunction

  function automatic logic ref_z(input logic [63:0] v, input logic e);
    return e && (v != 64'd0);
  endfunction

  // Scoreboard bookkeeping on the active edge (pre-edge values).
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid_h && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready_h) exp_q.push_back('{w: w, en: en});
    end
  end

  // Output monitor on the falling edge: every valid result must match the oldest beat.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_match", 64'(in_ready_l), 64'(in_ready_h));
      check("valid_match", 64'(out_valid_l), 64'(out_valid_h));
      if (out_valid_h) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid_h), 64'd0);
        end else begin
          check("y_high", 64'(y_h), 64'(ref_y(exp_q[0].w, exp_q[0].en, 1'b1)));
          check("z_high", 64'(z_h), 64'(ref_z(exp_q[0].w, exp_q[0].en)));
          check("y_low",  64'(y_l), 64'(ref_y(exp_q[0].w, exp_q[0].en, 1'b0)));
          check("z_low",  64'(z_l), 64'(ref_z(exp_q[0].w, exp_q[0].en)));
        end
      end
    end
  end

  task automatic upd_ready();
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      upd_ready();
    end
  endtask

  // Offer one beat and hold it until accepted; returns cycles taken.
  task automatic send(input logic [63:0] wv, input logic ev, output int cyc);
    logic acc;
    in_valid = 1'b1;
    w        = wv;
    en       = ev;
    cyc      = 0;
    acc      = 1'b0;
    while (!acc && cyc < 200) begin
      @(posedge clk);
      acc = in_ready_h;
      cyc++;
      #1;
      upd_ready();
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    w        = {$urandom, $urandom};
    en       = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() > 0 || out_valid_h) && n < 500) begin
      idle(1);
      n++;
    end
    if (n >= 500) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid_h), 64'd0);
    check("rst_y", 64'(y_h), 64'd0);
    check("rst_z", 64'(z_h), 64'd0);
    check("rst_in_ready", 64'(in_ready_h), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One lone beat: out_valid must rise exactly two edges after acceptance.
  task automatic latency_beat(input string tag);
    int c;
    out_ready = 1'b1;
    send(64'h1, 1'b1, c);
    check({tag, "_lat1"}, 64'(out_valid_h), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_lat2"}, 64'(out_valid_h), 64'd1);
    check({tag, "_y"}, 64'(y_h), 64'd0);
    check({tag, "_z"}, 64'(z_h), 64'd1);
    drain();
  endtask

  initial begin
    int c;
    logic [63:0] rv;
    vectors     = 0;
    miscompares = 0;
    rnd_ready   = 1'b0;
    rst         = 1'b1;
    en          = 1'b0;
    w           = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    do_reset();

    latency_beat("t1");

    // Extreme bits both set: polarity decides the winner.
    send(64'h8000_0000_0000_0001, 1'b1, c);
    drain();
    check("t2_y_high", 64'(y_h), 64'd63);
    check("t2_y_low",  64'(y_l), 64'd0);
    check("t2_z",      64'(z_h & z_l), 64'd1);

    // en=0 masks the word; en=1 encodes bit 40.
    send(64'h0000_0100_0000_0000, 1'b0, c);
    drain();
    check("t3_y_dis", 64'(y_h), 64'd0);
    check("t3_z_dis", 64'(z_h), 64'd0);
    send(64'h0000_0100_0000_0000, 1'b1, c);
    drain();
    check("t3_y_en", 64'(y_h), 64'd40);
    check("t3_z_en", 64'(z_h), 64'd1);

    // All-zero word with en=1 reports nothing set.
    send(64'h0, 1'b1, c);
    drain();
    check("zero_y", 64'(y_l), 64'd0);
    check("zero_z", 64'(z_l), 64'd0);

    // Walking one, full throughput: never stalls.
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      rv = 64'd1 << k;
      send(rv, 1'b1, c);
      check("t4_no_stall", 64'(c), 64'd1);
    end
    drain();

    // Consumer stall: two beats fill the pipe, then input backpressures.
    out_ready = 1'b0;
    send(64'h0000_0000_0000_0f00, 1'b1, c);
    send(64'h0010_0000_0000_0000, 1'b1, c);
    idle(3);
    check("t5_in_ready_low", 64'(in_ready_h), 64'd0);
    check("t5_held_y", 64'(y_h), 64'd11);
    check("t5_depth", 64'(exp_q.size()), 64'd2);
    drain();
    check("t5_last_y", 64'(y_h), 64'd52);

    // Reset with two beats in flight, then latency is intact.
    out_ready = 1'b0;
    send(64'h00ff_0000_0000_0000, 1'b1, c);
    send(64'h0000_0000_00ff_0000, 1'b1, c);
    idle(1);
    do_reset();
    latency_beat("t6");

    // Randomized stream with random gaps and consumer backpressure.
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: rv = 64'd1 << $urandom_range(0, 63);
        1: rv = {$urandom, $urandom};
        2: rv = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: rv = ($urandom_range(0, 1) != 0) ? 64'd0 : (64'd3 << $urandom_range(0, 62));
      endcase
      send(rv, ($urandom_range(0, 7) != 0), c);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
